gemm_insn_issue: RTL

//  Upstream issue stage of the GEMM core. Buffers 128-bit VTA instructions in a small FIFO
//  (valid/ready in), decodes loop bounds, and presents one instruction on insn to the GEMM

---
 rtl/gemm_insn_issue.sv | 135 +++++++++++++
 1 files changed

// File: rtl/gemm_insn_issue.sv
// GEMM issue stage: buffers VTA instructions in a small FIFO and holds each GEMM
// instruction on insn for its full loop-nest cycle count, then waits out the pipeline drain.
module gemm_insn_issue #(
  parameter int INS_WIDTH  = 128,
  parameter int DEPTH      = 4,
  parameter int PIPE_DEPTH = 4,
  parameter int CNT_WIDTH  = 42
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [INS_WIDTH-1:0]         in_insn,
  output logic [INS_WIDTH-1:0]         insn,
  output logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FCW = $clog2(DEPTH+1);
  localparam logic [2:0] OP_GEMM = 3'b010;

  typedef enum logic [1:0] {IDLE, LOAD, ISSUE, DRAIN} state_t;

  state_t                 state, state_n;
  logic [CNT_WIDTH-1:0]   cnt, cnt_n;
  logic                   start_n, done_n;
  logic [INS_WIDTH-1:0]   insn_reg;

  // ---------------- instruction FIFO ----------------
  logic [INS_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic                 push, pop;

  assign in_ready = (fifo_count < FCW'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = (state == IDLE) && (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_insn;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + FCW'(1);
        2'b01:   fifo_count <= fifo_count - FCW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------- decode ----------------
  logic [2:0]            opcode;
  logic [12:0]           uop_bgn;
  logic [13:0]           uop_end, iter_out, iter_in, uop_span;
  logic [CNT_WIDTH-1:0]  total;

  assign opcode   = insn_reg[2:0];
  assign uop_bgn  = insn_reg[20:8];
  assign uop_end  = insn_reg[34:21];
  assign iter_out = insn_reg[48:35];
  assign iter_in  = insn_reg[62:49];
  // An inverted or empty uop range issues nothing rather than wrapping.
  assign uop_span = (uop_end > {1'b0, uop_bgn}) ? (uop_end - {1'b0, uop_bgn}) : 14'd0;
  assign total    = CNT_WIDTH'(uop_span) * CNT_WIDTH'(iter_out) * CNT_WIDTH'(iter_in);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      start    <= 1'b0;
      done     <= 1'b0;
      insn_reg <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      start <= start_n;
      done  <= done_n;
      if (pop) insn_reg <= mem[rd_ptr];
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    start_n = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (fifo_count != '0) state_n = LOAD;
      end
      LOAD: begin
        cnt_n = total;
        if ((opcode == OP_GEMM) && (total != '0)) begin
          state_n = ISSUE;
          start_n = 1'b1;
        end else begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      ISSUE: begin
        cnt_n = cnt - CNT_WIDTH'(1);
        // cnt is reused as the drain down-counter once issuing ends.
        if (cnt == CNT_WIDTH'(1)) begin
          state_n = DRAIN;
          cnt_n   = CNT_WIDTH'(PIPE_DEPTH - 1);
        end
      end
      DRAIN: begin
        cnt_n = cnt - CNT_WIDTH'(1);
        if (cnt == '0) begin
          state_n = IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);
  assign insn = (state == ISSUE) ? insn_reg : '0;

endmodule
